host_mem_loader: RTL and testbench

Host-side session controller that drives the CPU's external memory ports. It streams a program into instruction memory and an initial image into data memory, then holds the CPU `enable` high for a programmed number of cycles. Afterwards it reads data memory back out as a result stream. It sits between the testbench/host link and the `cpu` top, acting as the initiator on the `addr_ext*`/`wen_ext*`/`ren_ext*` ports.

---
 rtl/host_mem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_host_mem_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_loader.sv
// host_mem_loader
// Host-side session controller for the CPU's external memory ports.
// A session streams a program into instruction memory, an initial image into
// data memory, enables the CPU for a programmed number of cycles, and then
// reads data memory back out as a result stream.
//
// Ports:
//   clk, arst_n                     clock, asynchronous active-low reset
//   start, imem_len, dmem_len,
//   run_cycles                      session request; lengths sampled at start
//   s_valid/s_ready/s_data          load stream (instruction words in [31:0])
//   m_valid/m_ready/m_data          dump stream
//   cpu_enable                      CPU enable
//   addr_ext/wen_ext/ren_ext/
//   wdata_ext                       instruction-memory external port
//   addr_ext_2/wen_ext_2/ren_ext_2/
//   wdata_ext_2/rdata_ext_2         data-memory external port
//   busy, done                      session status
module host_mem_loader #(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 10,
  parameter int RUN_W   = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start,
  input  logic [IMEM_AW:0]   imem_len,
  input  logic [DMEM_AW:0]   dmem_len,
  input  logic [RUN_W-1:0]   run_cycles,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [63:0]        s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [63:0]        m_data,
  output logic               cpu_enable,
  output logic [63:0]        addr_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  output logic [31:0]        wdata_ext,
  output logic [63:0]        addr_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  output logic [63:0]        wdata_ext_2,
  input  logic [63:0]        rdata_ext_2,
  output logic               busy,
  output logic               done
);

  // One extra index bit so the last capacity word is addressed without wrap.
  localparam int IDX_W = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;
  localparam logic [IMEM_AW:0] ICAP = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [DMEM_AW:0] DCAP = {1'b1, {DMEM_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IMEM_AW:0]   ilen_reg;
  logic [DMEM_AW:0]   dlen_reg;
  logic [RUN_W-1:0]   run_reg;
  logic [RUN_W-1:0]   run_cnt_reg;
  logic [63:0]        hold_reg;
  logic               done_reg;

  logic [IMEM_AW:0]   ilen_c;
  logic [DMEM_AW:0]   dlen_c;
  logic [IDX_W-1:0]   idx_inc;
  logic               last_i;
  logic               last_d;

  assign ilen_c  = (imem_len > ICAP) ? ICAP : imem_len;
  assign dlen_c  = (dmem_len > DCAP) ? DCAP : dmem_len;
  assign idx_inc = idx_reg + IDX_W'(1);
  assign last_i  = (idx_inc == IDX_W'(ilen_reg));
  assign last_d  = (idx_inc == IDX_W'(dlen_reg));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      ilen_reg    <= '0;
      dlen_reg    <= '0;
      run_reg     <= '0;
      run_cnt_reg <= '0;
      hold_reg    <= '0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            ilen_reg <= ilen_c;
            dlen_reg <= dlen_c;
            run_reg  <= run_cycles;
            idx_reg  <= '0;
            done_reg <= 1'b0;
            if (ilen_c != '0) begin
              state_reg <= LOAD_I;
            end else if (dlen_c != '0) begin
              state_reg <= LOAD_D;
            end else if (run_cycles != '0) begin
              state_reg   <= RUN;
              run_cnt_reg <= run_cycles;
            end else begin
              // Nothing to do: complete immediately without leaving IDLE.
              done_reg <= 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (s_valid) begin
            if (last_i) begin
              idx_reg <= '0;
              if (dlen_reg != '0) begin
                state_reg <= LOAD_D;
              end else if (run_reg != '0) begin
                state_reg   <= RUN;
                run_cnt_reg <= run_reg;
              end else begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end
            end else begin
              idx_reg <= idx_inc;
            end
          end
        end
        LOAD_D: begin
          if (s_valid) begin
            if (last_d) begin
              idx_reg <= '0;
              if (run_reg != '0) begin
                state_reg   <= RUN;
                run_cnt_reg <= run_reg;
              end else begin
                // dlen is non-zero here, so the dump phase always follows.
                state_reg <= DUMP_RD;
              end
            end else begin
              idx_reg <= idx_inc;
            end
          end
        end
        RUN: begin
          if (run_cnt_reg == RUN_W'(1)) begin
            idx_reg <= '0;
            if (dlen_reg != '0) begin
              state_reg <= DUMP_RD;
            end else begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end else begin
            run_cnt_reg <= run_cnt_reg - RUN_W'(1);
          end
        end
        DUMP_RD: state_reg <= DUMP_CAP;
        DUMP_CAP: begin
          // SRAM read data is valid one cycle after the ren strobe.
          hold_reg  <= rdata_ext_2;
          state_reg <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (m_ready) begin
            if (last_d) begin
              idx_reg   <= '0;
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              idx_reg   <= idx_inc;
              state_reg <= DUMP_RD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write strobes follow s_valid in the same cycle so loads run at one word
  // per cycle; every output is gated by state so reset zeroes it at once.
  assign s_ready     = (state_reg == LOAD_I) || (state_reg == LOAD_D);
  assign wen_ext     = (state_reg == LOAD_I) && s_valid;
  assign addr_ext    = (state_reg == LOAD_I) ? 64'({idx_reg, 2'b00}) : 64'd0;
  assign wdata_ext   = (state_reg == LOAD_I) ? s_data[31:0] : 32'd0;
  assign ren_ext     = 1'b0;
  assign wen_ext_2   = (state_reg == LOAD_D) && s_valid;
  assign ren_ext_2   = (state_reg == DUMP_RD);
  assign addr_ext_2  = ((state_reg == LOAD_D) || (state_reg == DUMP_RD)) ?
                       64'({idx_reg, 3'b000}) : 64'd0;
  assign wdata_ext_2 = (state_reg == LOAD_D) ? s_data : 64'd0;
  assign cpu_enable  = (state_reg == RUN);
  assign m_valid     = (state_reg == DUMP_OUT);
  assign m_data      = (state_reg == DUMP_OUT) ? hold_reg : 64'd0;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_host_mem_loader.sv
// Testbench for host_mem_loader: directed sessions; expected events are queued
// by the stimulus and popped by an independent monitor on the falling edge.
module tb_host_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  imem_len = '0;
  logic [10:0] dmem_len = '0;
  logic [31:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic        busy;
  logic        done;

  host_mem_loader #(.IMEM_AW(9), .DMEM_AW(10), .RUN_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Data-memory model: synchronous write, one-cycle registered read.
  logic [63:0] dmem [0:1023];
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event kinds: 0 imem write, 1 dmem write, 2 dump beat, 3 run window, 4 done rise.
  // gap = cycles since the previous event (start, write, beat, last enable cycle);
  // a gap of 0 means "not checked".
  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] data;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic void ex(input int kind, input logic [63:0] a,
                             input logic [63:0] d, input int g);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.gap = g;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_evt(input int kind, input logic [63:0] addr,
                           input logic [63:0] data, input int gap);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none",
               kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== addr || e.data !== data ||
          (e.gap != 0 && e.gap != gap)) begin
        failures++;
        $display("FAIL event actual kind=%0d addr=%h data=%h gap=%0d required kind=%0d addr=%h data=%h gap=%0d",
                 kind, addr, data, gap, e.kind, e.addr, e.data, e.gap);
      end else begin
        $display("ok event kind=%0d addr=%h data=%h gap=%0d", kind, addr, data, gap);
      end
    end
  endtask

  // Monitor
  int          last_cyc = 0;
  int          en_cnt = 0;
  int          en_gap = 0;
  logic        en_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic        mv_prev = 1'b0;
  logic        mr_prev = 1'b0;
  logic [63:0] md_prev = '0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (start && !busy) last_cyc = cyc;
      if (wen_ext) begin
        chk("wen_needs_valid", 64'(s_valid), 64'd1);
        chk("wen_vs_enable", 64'(cpu_enable), 64'd0);
        check_evt(0, addr_ext, {32'd0, wdata_ext}, cyc - last_cyc);
        last_cyc = cyc;
      end
      if (wen_ext_2) begin
        chk("wen2_needs_valid", 64'(s_valid), 64'd1);
        chk("wen2_vs_enable", 64'(cpu_enable), 64'd0);
        check_evt(1, addr_ext_2, wdata_ext_2, cyc - last_cyc);
        last_cyc = cyc;
      end
      if (mv_prev && !mr_prev) begin
        chk("m_hold_valid", 64'(m_valid), 64'd1);
        chk("m_hold_data", m_data, md_prev);
      end
      if (m_valid && m_ready) begin
        check_evt(2, 64'd0, m_data, cyc - last_cyc);
        last_cyc = cyc;
      end
      if (cpu_enable) begin
        if (!en_prev) begin
          en_cnt = 0;
          en_gap = cyc - last_cyc;
        end
        en_cnt++;
      end else if (en_prev) begin
        check_evt(3, 64'd0, 64'(en_cnt), en_gap);
        last_cyc = cyc - 1;
      end
      if (done && !done_prev) check_evt(4, 64'd0, 64'd0, cyc - last_cyc);
      en_prev   = cpu_enable;
      done_prev = done;
      mv_prev   = m_valid;
      mr_prev   = m_ready;
      md_prev   = m_data;
    end else begin
      en_prev = 1'b0; done_prev = 1'b0; mv_prev = 1'b0; mr_prev = 1'b0;
    end
  end

  // Stimulus tasks: each is entered and left 1 time unit after a rising edge.
  task automatic do_start(input logic [9:0] il, input logic [10:0] dl, input logic [31:0] rc);
    imem_len = il; dmem_len = dl; run_cycles = rc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] d);
    logic got;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL push_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int maxc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      got = done;
      @(posedge clk); #1;
    end
    chk("done_wait", 64'(got), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_wen_ext_2", 64'(wen_ext_2), 64'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Instruction load: 4 words, upper s_data bits ignored
    ex(0, 64'd0,  64'h0000_0013, 1);
    ex(0, 64'd4,  64'h0010_0093, 1);
    ex(0, 64'd8,  64'h0020_0113, 1);
    ex(0, 64'd12, 64'h0030_0193, 1);
    ex(4, 64'd0, 64'd0, 1);
    do_start(10'd4, 11'd0, 32'd0);
    push_word(64'hFFFF_FFFF_0000_0013);
    push_word(64'hFFFF_FFFF_0010_0093);
    push_word(64'hFFFF_FFFF_0020_0113);
    push_word(64'hFFFF_FFFF_0030_0193);
    wait_done(20);

    // Load backpressure then full-rate dump of the same 3 words
    m_ready = 1'b1;
    ex(1, 64'd0,  64'h1111_2222_3333_4444, 1);
    ex(1, 64'd8,  64'h5555_6666_7777_8888, 2);
    ex(1, 64'd16, 64'h9999_AAAA_BBBB_CCCC, 1);
    ex(2, 64'd0, 64'h1111_2222_3333_4444, 3);
    ex(2, 64'd0, 64'h5555_6666_7777_8888, 3);
    ex(2, 64'd0, 64'h9999_AAAA_BBBB_CCCC, 3);
    ex(4, 64'd0, 64'd0, 1);
    do_start(10'd0, 11'd3, 32'd0);
    push_word(64'h1111_2222_3333_4444);
    idle_cycle();
    push_word(64'h5555_6666_7777_8888);
    push_word(64'h9999_AAAA_BBBB_CCCC);
    wait_done(40);

    // Run window of 5 cycles right after a 2-word program load
    ex(0, 64'd0, 64'h0000_0093, 1);
    ex(0, 64'd4, 64'h0000_0113, 1);
    ex(3, 64'd0, 64'd5, 1);
    ex(4, 64'd0, 64'd0, 1);
    do_start(10'd2, 11'd0, 32'd5);
    push_word(64'h0000_0000_0000_0093);
    push_word(64'h0000_0000_0000_0113);
    wait_done(30);

    // Dump backpressure: m_ready low for 4 cycles on the first beat
    m_ready = 1'b0;
    ex(1, 64'd0, 64'h0000_0000_0000_DEAD, 1);
    ex(1, 64'd8, 64'h0000_0000_0000_BEEF, 1);
    ex(2, 64'd0, 64'h0000_0000_0000_DEAD, 0);
    ex(2, 64'd0, 64'h0000_0000_0000_BEEF, 3);
    ex(4, 64'd0, 64'd0, 1);
    do_start(10'd0, 11'd2, 32'd0);
    push_word(64'h0000_0000_0000_DEAD);
    push_word(64'h0000_0000_0000_BEEF);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m_valid;
    end
    chk("m_valid_wait", 64'(got), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_done(30);

    // Clamp: 600 requested, capacity 512
    for (int i = 0; i < 512; i++) ex(0, 64'(i * 4), 64'(32'hA000_0000 + i), 1);
    ex(4, 64'd0, 64'd0, 1);
    do_start(10'd600, 11'd0, 32'd0);
    for (int i = 0; i < 512; i++) push_word({32'd0, 32'hA000_0000 + 32'(i)});
    wait_done(10);
    chk("clamp_idle_ready", 64'(s_ready), 64'd0);

    // Reset mid LOAD_I after 3 writes
    ex(0, 64'd0, 64'h0000_0001, 1);
    ex(0, 64'd4, 64'h0000_0002, 1);
    ex(0, 64'd8, 64'h0000_0003, 1);
    do_start(10'd8, 11'd0, 32'd0);
    push_word(64'd1);
    push_word(64'd2);
    push_word(64'd3);
    s_valid = 1'b1;
    s_data  = 64'd4;
    #1;
    chk("pre_rst_wen", 64'(wen_ext), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_wen_ext", 64'(wen_ext), 64'd0);
    chk("mid_rst_addr_ext", addr_ext, 64'd0);
    chk("mid_rst_wdata_ext", 64'(wdata_ext), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);

    // All lengths zero: done next cycle, no strobes
    ex(4, 64'd0, 64'd0, 1);
    do_start(10'd0, 11'd0, 32'd0);
    wait_done(5);
    chk("zero_busy", 64'(busy), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
